// File: rtl/aes_core_seq.sv
// aes_core_seq: host-side sequencer for a 32-bit-serial AES core (block handshake, load, wait, unload).
// Optional AES_SEQ_PERF_EN adds perf_ops/perf_stall saturating counters.
module aes_core_seq #(
  parameter int INIT_CYC    = 88,
  parameter int START_CYC   = 2,
  parameter int COMPUTE_CYC = 79,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic [127:0] in_key,
  input  logic [127:0] in_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out,
  output logic         core_start,
  output logic         core_sel_dec,
  output logic [127:0] core_key,
  output logic [31:0]  core_data_in,
  input  logic [31:0]  core_data_out
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [31:0]  perf_ops,
  output logic [31:0]  perf_stall
`endif
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_START, S_LOAD, S_WAIT, S_UNLOAD, S_DONE} state_t;
  localparam logic [CNT_W-1:0] C_INIT  = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] C_START = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] C_COMP  = CNT_W'(COMPUTE_CYC - 1);
  localparam logic [CNT_W-1:0] C_WORD  = CNT_W'(3);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready, r_out_valid, r_start, r_dec;
  logic [127:0]       r_key, r_text, r_text_out;
  logic [31:0]        r_data_in;
  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign text_out     = r_text_out;
  assign core_start   = r_start;
  assign core_sel_dec = r_dec;
  assign core_key     = r_key;
  assign core_data_in = r_data_in;
  // r_text is consumed MSW-first by shifting left one word per load cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_dec       <= 1'b0;
      r_key       <= '0;
      r_text      <= '0;
      r_text_out  <= '0;
      r_data_in   <= '0;
    end else begin
      case (r_state)
        S_INIT:
          if (r_cnt == C_INIT) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        S_IDLE:
          if (in_valid) begin
            r_state    <= S_START;
            r_in_ready <= 1'b0;
            r_key      <= in_key;
            r_dec      <= in_dec;
            r_text     <= in_text;
            r_start    <= 1'b1;
            r_cnt      <= C_START;
          end
        S_START:
          if (r_cnt == '0) begin
            r_state   <= S_LOAD;
            r_start   <= 1'b0;
            r_data_in <= r_text[127:96];
            r_text    <= {r_text[95:0], 32'h0};
            r_cnt     <= C_WORD;
          end else r_cnt <= r_cnt - 1'b1;
        S_LOAD:
          if (r_cnt == '0) begin
            r_state   <= S_WAIT;
            r_data_in <= '0;
            r_cnt     <= C_COMP;
          end else begin
            r_data_in <= r_text[127:96];
            r_text    <= {r_text[95:0], 32'h0};
            r_cnt     <= r_cnt - 1'b1;
          end
        S_WAIT:
          if (r_cnt == '0) begin
            r_state <= S_UNLOAD;
            r_cnt   <= C_WORD;
          end else r_cnt <= r_cnt - 1'b1;
        S_UNLOAD: begin
          r_text_out <= {r_text_out[95:0], core_data_out};
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_DONE:
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        default: r_state <= S_INIT;
      endcase
    end
  end
`ifdef AES_SEQ_PERF_EN
  logic [31:0] r_perf_ops, r_perf_stall;
  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_out_valid && out_ready && r_perf_ops != '1) r_perf_ops <= r_perf_ops + 1'b1;
      if (r_state == S_DONE && !out_ready && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_aes_core_seq.sv
// tb_aes_core_seq: directed bench for aes_core_seq; the bench plays the AES core with known-answer words.
module tb_aes_core_seq;
  logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, in_dec = 1'b0;
  logic [127:0] in_key = '0, in_text = '0, text_out, core_key;
  logic         out_valid, out_ready = 1'b0, core_start, core_sel_dec;
  logic [31:0]  core_data_in, core_data_out = 32'hdeadbeef;
`ifdef AES_SEQ_PERF_EN
  logic [31:0]  perf_ops, perf_stall;
`endif
  int n_chk = 0, n_pass = 0;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_core_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
    .in_key(in_key), .in_text(in_text), .out_valid(out_valid), .out_ready(out_ready),
    .text_out(text_out), .core_start(core_start), .core_sel_dec(core_sel_dec),
    .core_key(core_key), .core_data_in(core_data_in), .core_data_out(core_data_out)
`ifdef AES_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ctrl", {in_ready, out_valid, core_start, core_sel_dec, core_key, core_data_in}, '0);
    chk("rst_text", text_out, '0);
  endtask

  // Called just after the reset edge with reset released; counts INIT cycles until in_ready.
  task automatic init_wait();
    int n = 0;
    logic seen_ov = 1'b0;
    while (!in_ready && n < 200) begin
      step();
      n++;
      seen_ov |= out_valid;
    end
    chk("init_len", n, 88);
    chk("init_no_ov", seen_ov, 1'b0);
  endtask

  task automatic run_op(input logic dec, input logic [127:0] txt, input logic [127:0] res,
                        input int stall, input logic hold, output int waited);
    logic [127:0] t = txt, r = res;
    logic [31:0]  w;
    waited = 0;
    in_valid = 1'b1;
    in_dec   = dec;
    in_key   = KEY;
    in_text  = txt;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept", in_ready, 1'b1);
      return;
    end
    step();
    if (!hold) in_valid = 1'b0;
    for (int k = 1; k <= 89; k++) begin
      core_data_out = (k >= 86) ? r[127-32*(k-86) -: 32] : 32'hdeadbeef;
      w = (k >= 3 && k <= 6) ? t[127-32*(k-3) -: 32] : 32'h0;
      chk($sformatf("seq_k%0d", k), {core_start, w == w ? core_data_in : 32'h0, out_valid, in_ready, core_sel_dec, core_key},
          {(k <= 2), w, 1'b0, 1'b0, dec, KEY});
      step();
    end
    core_data_out = 32'hdeadbeef;
    chk("done_ov", out_valid, 1'b1);
    chk("done_text", text_out, res);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = s[0];
      step();
      chk("stall", {out_valid, in_ready, core_sel_dec, text_out}, {1'b1, 1'b0, dec, res});
    end
    if (stall > 0) in_valid = hold;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs", {out_valid, in_ready, text_out}, {1'b0, 1'b1, res});
  endtask

  initial begin
    int waited;
    in_valid = 1'b1;
    repeat (2) step();
    chk_reset_vals();
    reset = 1'b0;
    init_wait();
    run_op(1'b0, PT, CT, 20, 1'b0, waited);
    chk("stall_no_accept", {in_ready, out_valid}, 2'b10);
`ifdef AES_SEQ_PERF_EN
    chk("perf_stall", perf_stall, 20);
    chk("perf_ops", perf_ops, 1);
`endif
    run_op(1'b1, CT, PT, 0, 1'b0, waited);
    // reset mid-operation
    in_valid = 1'b1;
    in_key   = KEY;
    in_text  = PT;
    in_dec   = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    repeat (29) step();
    chk("pre_rst_busy", {in_ready, core_key}, {1'b0, KEY});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals();
    init_wait();
`ifdef AES_SEQ_PERF_EN
    chk("perf_rst", {perf_ops, perf_stall}, '0);
`endif
    run_op(1'b0, PT, CT, 0, 1'b1, waited);
    run_op(1'b0, PT, CT, 0, 1'b0, waited);
    chk("b2b_gap", waited, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
